dnn_frame_buffer: RTL

- Parametrised, double-buffered input framer placed in front of the DNN core.
- Collects a serial stream of signed feature samples (vec_in/dv_in) into frames of NUM_FEAT words.
- Scales and saturates each sample from IN_W to DATA_W.
- Hands each complete frame to the core through a valid/ack handshake with a random-access read port.
- Adds behaviour the current input path lacks: ping-pong banking, overflow dropping and gap-timeout frame abort.

---
 rtl/dnn_pkg.sv | 24 ++
 rtl/dnn_sat_shift.sv | 31 +++
 rtl/dnn_frame_buffer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/dnn_pkg.sv
// Shared definitions for the DNN input path: write-FSM encoding,
// default geometry and saturation bounds for a signed word width.
package dnn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DROP = 2'd2
  } wr_state_t;

  localparam int DNN_NUM_FEAT = 12;
  localparam int DNN_IN_W     = 26;

  // Largest value representable in a dw-bit two's complement word.
  function automatic longint sat_max(input int dw);
    return (longint'(64'sd1) <<< (dw - 1)) - 64'sd1;
  endfunction

  // Smallest value representable in a dw-bit two's complement word.
  function automatic longint sat_min(input int dw);
    return -(longint'(64'sd1) <<< (dw - 1));
  endfunction

endpackage

// File: rtl/dnn_sat_shift.sv
// Combinational arithmetic right shift followed by saturation from
// IN_W to DATA_W bits. Assumes IN_W >= DATA_W.
module dnn_sat_shift
  import dnn_pkg::*;
#(
  parameter int IN_W   = 26,
  parameter int DATA_W = 16,
  parameter int SHIFT  = 2
) (
  input  logic signed [IN_W-1:0]   din,
  output logic signed [DATA_W-1:0] dout
);

  localparam logic signed [IN_W-1:0] MAX_V = IN_W'(sat_max(DATA_W));
  localparam logic signed [IN_W-1:0] MIN_V = IN_W'(sat_min(DATA_W));

  logic signed [IN_W-1:0] shifted;

  // Floor-divide by 2^SHIFT, then clamp into the DATA_W range.
  always_comb begin
    shifted = din >>> SHIFT;
    if (shifted > MAX_V) begin
      dout = MAX_V[DATA_W-1:0];
    end else if (shifted < MIN_V) begin
      dout = MIN_V[DATA_W-1:0];
    end else begin
      dout = shifted[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/dnn_frame_buffer.sv
// Double-buffered input framer: packs a serial sample stream into
// NUM_FEAT-word frames in two ping-pong banks and presents completed
// frames to the DNN core through a random-access read port.
//
// Read-side handshake: frame_valid is high while the bank at rd_bank
// holds a complete frame. The core reads freely via rd_addr, then
// pulses frame_ack for one cycle; an ack seen while frame_valid is high
// frees that bank and moves to the other one, an ack while frame_valid
// is low has no effect. A new frame is only written into a free bank;
// when both are full the incoming frame is counted through and dropped.
module dnn_frame_buffer
  import dnn_pkg::*;
#(
  parameter int IN_W     = DNN_IN_W,
  parameter int DATA_W   = 16,
  parameter int SHIFT    = 2,
  parameter int NUM_FEAT = DNN_NUM_FEAT,
  parameter int GAP_MAX  = 4,
  localparam int AW      = $clog2(NUM_FEAT)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [IN_W-1:0]   vec_in,
  input  logic                     dv_in,
  input  logic [AW-1:0]            rd_addr,
  output logic signed [DATA_W-1:0] rd_data,
  output logic                     frame_valid,
  input  logic                     frame_ack,
  output logic                     overflow,
  output logic                     frame_err,
  output logic [7:0]               frame_cnt
);

  localparam int GW = $clog2(GAP_MAX + 1);
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_FEAT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_MAX - 1);

  wr_state_t state, state_n;
  logic [AW-1:0] wr_cnt, wr_cnt_n;
  logic [GW-1:0] gap_cnt, gap_cnt_n;
  logic          wr_bank, rd_bank;
  logic [1:0]    full;
  logic          we, complete, drop_start, abort;
  logic signed [DATA_W-1:0] sample;
  logic signed [DATA_W-1:0] mem [2][NUM_FEAT];

  dnn_sat_shift #(
    .IN_W  (IN_W),
    .DATA_W(DATA_W),
    .SHIFT (SHIFT)
  ) u_sat (
    .din (vec_in),
    .dout(sample)
  );

  assign frame_valid = full[rd_bank];

  // Write FSM next-state: fill a free bank, or count through a dropped frame;
  // a run of GAP_MAX idle cycles inside a frame aborts it.
  always_comb begin
    state_n    = state;
    wr_cnt_n   = wr_cnt;
    gap_cnt_n  = gap_cnt;
    we         = 1'b0;
    complete   = 1'b0;
    drop_start = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        gap_cnt_n = '0;
        if (dv_in) begin
          wr_cnt_n = AW'(1);
          if (full[wr_bank]) begin
            drop_start = 1'b1;
            state_n    = DROP;
          end else begin
            we      = 1'b1;
            state_n = FILL;
          end
        end
      end
      FILL, DROP: begin
        if (dv_in) begin
          gap_cnt_n = '0;
          we        = (state == FILL);
          if (wr_cnt == LAST_IDX) begin
            wr_cnt_n = '0;
            complete = (state == FILL);
            state_n  = IDLE;
          end else begin
            wr_cnt_n = wr_cnt + 1'b1;
          end
        end else if (gap_cnt == GAP_LAST) begin
          wr_cnt_n  = '0;
          gap_cnt_n = '0;
          abort     = 1'b1;
          state_n   = IDLE;
        end else begin
          gap_cnt_n = gap_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, bank bookkeeping and status outputs. Completion and ack always
  // touch different banks, so both may update full[] in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      wr_cnt    <= '0;
      gap_cnt   <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      full      <= '0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state     <= state_n;
      wr_cnt    <= wr_cnt_n;
      gap_cnt   <= gap_cnt_n;
      frame_err <= abort;
      if (drop_start) begin
        overflow <= 1'b1;
      end
      if (complete) begin
        full[wr_bank] <= 1'b1;
        wr_bank       <= ~wr_bank;
        frame_cnt     <= frame_cnt + 8'd1;
      end
      if (frame_ack && full[rd_bank]) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
      end
    end
  end

  // Bank storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_bank][wr_cnt] <= sample;
    end
  end

  // Registered read port; addresses past the frame return zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_data <= '0;
    end else if ({1'b0, rd_addr} < (AW + 1)'(NUM_FEAT)) begin
      rd_data <= mem[rd_bank][rd_addr];
    end else begin
      rd_data <= '0;
    end
  end

endmodule
